// File: rtl/pmp_iter_checker.sv
// pmp_iter_checker: multi-cycle PMP check of a sized access,
// scanning LANES entries per cycle behind valid/ready handshakes.
module pmp_iter_checker #(
  parameter int PA_BITS     = 56,
  parameter int PMP_ENTRIES = 16,
  parameter int LANES       = 4,
  parameter int IDX_BITS    = $clog2(PMP_ENTRIES)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             ReqValid,
  output logic                             ReqReady,
  input  logic [PA_BITS-1:0]               PhysicalAddress,
  input  logic [1:0]                       Size,
  input  logic [2:0]                       AccessType,
  input  logic [1:0]                       PrivilegeMode,
  input  logic [8*PMP_ENTRIES-1:0]         PMPCfg,
  input  logic [(PA_BITS-2)*PMP_ENTRIES-1:0] PMPAdr,
  input  logic                             CsrWrite,
  output logic                             RespValid,
  input  logic                             RespReady,
  output logic                             Fault,
  output logic                             MatchValid,
  output logic [IDX_BITS-1:0]              MatchIdx
);

  localparam int AW = PA_BITS - 2;
  localparam int NG = PMP_ENTRIES / LANES;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_t;

  state_t state, state_n;

  logic [AW-1:0]       lo_w, hi_w;
  logic                ovf;
  logic [2:0]          acc;
  logic                priv_m;
  logic [GW-1:0]       grp;
  logic                carry_lo, carry_hi;
  logic                fault_q, match_q;
  logic [IDX_BITS-1:0] idx_q;

  logic [2:0]          off;
  logic [1:0]          wcarry;
  logic [AW:0]         hi_ext;

  logic                hit, hit_full, hit_lock;
  logic [2:0]          hit_perm;
  logic [IDX_BITS-1:0] hit_idx;
  logic                nxt_lo, nxt_hi;
  logic                last;

  logic                fault_n, match_n;
  logic [IDX_BITS-1:0] idx_n;

  // Byte offset of the last byte within the access
  always_comb begin
    off = 3'd0;
    unique case (Size)
      2'd0: off = 3'd0;
      2'd1: off = 3'd1;
      2'd2: off = 3'd3;
      default: off = 3'd7;
    endcase
  end

  assign wcarry = 2'(({2'b0, PhysicalAddress[1:0]} + {1'b0, off}) >> 2);
  assign hi_ext = {1'b0, PhysicalAddress[PA_BITS-1:2]}
                + {{(AW-1){1'b0}}, wcarry};

  assign last = (grp == GW'(NG - 1));

  // Match the current group of entries, lowest hit wins
  always_comb begin
    int           e;
    logic [AW-1:0] a, msk;
    logic         ge_lo, ge_hi, mlo, mhi, plo, phi;
    e        = 0;
    a        = '0;
    msk      = '0;
    ge_lo    = 1'b0;
    ge_hi    = 1'b0;
    mlo      = 1'b0;
    mhi      = 1'b0;
    plo      = carry_lo;
    phi      = carry_hi;
    hit      = 1'b0;
    hit_full = 1'b0;
    hit_lock = 1'b0;
    hit_perm = 3'b000;
    hit_idx  = '0;
    for (int l = 0; l < LANES; l++) begin
      e     = int'(grp) * LANES + l;
      a     = PMPAdr[AW*e +: AW];
      msk   = a ^ (a + 1'b1);
      ge_lo = (lo_w >= a);
      ge_hi = (hi_w >= a);
      unique case (PMPCfg[8*e+3 +: 2])
        2'b01: begin
          mlo = plo & ~ge_lo;
          mhi = phi & ~ge_hi;
        end
        2'b10: begin
          mlo = (lo_w == a);
          mhi = (hi_w == a);
        end
        2'b11: begin
          mlo = (((lo_w ^ a) & ~msk) == '0);
          mhi = (((hi_w ^ a) & ~msk) == '0);
        end
        default: begin
          mlo = 1'b0;
          mhi = 1'b0;
        end
      endcase
      if (!hit && (mlo | mhi)) begin
        hit      = 1'b1;
        hit_full = mlo & mhi;
        hit_perm = PMPCfg[8*e +: 3];
        hit_lock = PMPCfg[8*e+7];
        hit_idx  = IDX_BITS'(e);
      end
      plo = ge_lo;
      phi = ge_hi;
    end
    nxt_lo = plo;
    nxt_hi = phi;
  end

  // Next state and the result to register on leaving SCAN
  always_comb begin
    state_n = state;
    fault_n = 1'b0;
    match_n = 1'b0;
    idx_n   = '0;
    unique case (1'b1)
      ovf: fault_n = 1'b1;
      (hit && !hit_full): fault_n = 1'b1;
      (hit && hit_full): begin
        match_n = 1'b1;
        idx_n   = hit_idx;
        fault_n = (~priv_m | hit_lock) & ~|(hit_perm & acc);
      end
      default: fault_n = ~priv_m;
    endcase
    unique case (state)
      IDLE: if (ReqValid) state_n = SCAN;
      SCAN: if (!CsrWrite && (hit || last)) state_n = RESP;
      RESP: if (RespReady) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Request capture, group walk and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_w     <= '0;
      hi_w     <= '0;
      ovf      <= 1'b0;
      acc      <= 3'b000;
      priv_m   <= 1'b0;
      grp      <= '0;
      carry_lo <= 1'b0;
      carry_hi <= 1'b0;
      fault_q  <= 1'b0;
      match_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      unique case (state)
        IDLE: if (ReqValid) begin
          lo_w     <= PhysicalAddress[PA_BITS-1:2];
          hi_w     <= hi_ext[AW-1:0];
          ovf      <= hi_ext[AW];
          acc      <= AccessType;
          priv_m   <= &PrivilegeMode;
          grp      <= '0;
          carry_lo <= 1'b1;
          carry_hi <= 1'b1;
        end
        SCAN: begin
          if (CsrWrite) begin
            grp      <= '0;
            carry_lo <= 1'b1;
            carry_hi <= 1'b1;
          end else if (hit || last) begin
            fault_q <= fault_n;
            match_q <= match_n;
            idx_q   <= idx_n;
          end else begin
            grp      <= grp + 1'b1;
            carry_lo <= nxt_lo;
            carry_hi <= nxt_hi;
          end
        end
        default: ;
      endcase
    end
  end

  assign ReqReady   = (state == IDLE);
  assign RespValid  = (state == RESP);
  assign Fault      = fault_q;
  assign MatchValid = match_q;
  assign MatchIdx   = idx_q;

endmodule

// File: tb/tb_pmp_iter_checker.sv
// tb_pmp_iter_checker: directed bench with a byte-range
// PMP model and a per-cycle response checker.
module tb_pmp_iter_checker;

  localparam int PA = 56;
  localparam int N  = 16;
  localparam int L  = 4;
  localparam int IW = 4;
  localparam int AW = PA - 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ReqValid = 1'b0;
  logic              ReqReady;
  logic [PA-1:0]     PhysicalAddress = '0;
  logic [1:0]        Size = '0;
  logic [2:0]        AccessType = '0;
  logic [1:0]        PrivilegeMode = '0;
  logic [8*N-1:0]    PMPCfg;
  logic [AW*N-1:0]   PMPAdr;
  logic              CsrWrite = 1'b0;
  logic              RespValid;
  logic              RespReady = 1'b1;
  logic              Fault;
  logic              MatchValid;
  logic [IW-1:0]     MatchIdx;

  logic [7:0]    cfg  [N];
  logic [AW-1:0] adr  [N];
  logic [7:0]    pcfg [N];
  logic [AW-1:0] padr [N];

  int vecs = 0;
  int errs = 0;

  logic exp_on = 1'b0;
  logic e_f, e_mv;
  int   e_idx, e_k;

  logic gf, gmv;
  int   gidx, glat;

  always #5 clk = ~clk;

  pmp_iter_checker #(
    .PA_BITS(PA), .PMP_ENTRIES(N), .LANES(L), .IDX_BITS(IW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .PhysicalAddress(PhysicalAddress), .Size(Size),
    .AccessType(AccessType), .PrivilegeMode(PrivilegeMode),
    .PMPCfg(PMPCfg), .PMPAdr(PMPAdr), .CsrWrite(CsrWrite),
    .RespValid(RespValid), .RespReady(RespReady),
    .Fault(Fault), .MatchValid(MatchValid), .MatchIdx(MatchIdx)
  );

  always_comb begin
    PMPCfg = '0;
    PMPAdr = '0;
    for (int i = 0; i < N; i++) begin
      PMPCfg[8*i +: 8]   = cfg[i];
      PMPAdr[AW*i +: AW] = adr[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic inreg(int i, logic [63:0] x);
    logic [63:0] b, sz, lb;
    int t;
    b = {8'b0, adr[i], 2'b00};
    case (cfg[i][4:3])
      2'b01: begin
        lb = 64'd0;
        if (i > 0) lb = {8'b0, adr[i-1], 2'b00};
        return (x >= lb) && (x < b);
      end
      2'b10: return (x >= b) && (x < b + 64'd4);
      2'b11: begin
        t = 0;
        while (t < AW && adr[i][t]) t++;
        sz = 64'd1 << (t + 3);
        b  = b & ~(sz - 64'd1);
        return (x >= b) && (x < b + sz);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic model(input logic [63:0] addr, input logic [1:0] sz,
                       input logic [2:0] acc, input logic [1:0] priv,
                       output logic f, output logic mv,
                       output int idx, output int k);
    logic [63:0] lo, hi;
    logic ovf, enf;
    int term;
    lo   = addr;
    hi   = lo + (64'd1 << sz) - 64'd1;
    ovf  = hi[PA];
    hi   = hi & ((64'd1 << PA) - 64'd1);
    term = -1;
    for (int i = 0; i < N; i++)
      if (term < 0 && (inreg(i, lo) || inreg(i, hi))) term = i;
    mv  = 1'b0;
    idx = 0;
    k   = (term < 0) ? N / L : term / L + 1;
    if (ovf) f = 1'b1;
    else if (term < 0) f = (priv != 2'b11);
    else if (inreg(term, lo) != inreg(term, hi)) f = 1'b1;
    else begin
      mv  = 1'b1;
      idx = term;
      enf = (priv != 2'b11) || cfg[term][7];
      f   = enf && ((cfg[term][2:0] & acc) == 3'b000);
    end
  endtask

  // Compare every valid response cycle against the model
  always @(negedge clk) begin
    if (reset_n && RespValid) begin
      chk("resp_expected", RespValid, exp_on);
      if (exp_on) begin
        chk("fault", Fault, e_f);
        chk("match_valid", MatchValid, e_mv);
        if (e_mv) chk("match_idx", MatchIdx, e_idx);
        chk("req_ready_in_resp", ReqReady, 0);
      end
    end
  end

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      cfg[i] = 8'h00;
      adr[i] = '0;
    end
  endtask

  task automatic run(input logic [63:0] addr, input logic [1:0] sz,
                     input logic [2:0] acc, input logic [1:0] priv,
                     input int hold, input int csr_at);
    model(addr, sz, acc, priv, e_f, e_mv, e_idx, e_k);
    @(negedge clk);
    ReqValid        = 1'b1;
    PhysicalAddress = addr[PA-1:0];
    Size            = sz;
    AccessType      = acc;
    PrivilegeMode   = priv;
    RespReady       = (hold == 0);
    exp_on          = 1'b1;
    @(posedge clk);
    #1;
    ReqValid = 1'b0;
    glat = 0;
    while (!RespValid && glat < 64) begin
      if (csr_at > 0 && glat == csr_at - 1) begin
        cfg = pcfg;
        adr = padr;
        CsrWrite = 1'b1;
        model(addr, sz, acc, priv, e_f, e_mv, e_idx, e_k);
        e_k = e_k + csr_at;
      end else begin
        CsrWrite = 1'b0;
      end
      @(posedge clk);
      #1;
      glat++;
    end
    CsrWrite = 1'b0;
    chk("latency", glat, e_k);
    gf   = Fault;
    gmv  = MatchValid;
    gidx = int'(MatchIdx);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
    end
    RespReady = 1'b1;
    @(posedge clk);
    #1;
    chk("resp_drop", RespValid, 0);
    chk("ready_back", ReqReady, 1);
    exp_on = 1'b0;
  endtask

  task automatic setup_napot();
    clear_cfg();
    adr[9] = 54'h2000_01FF;
    cfg[9] = 8'h19;
  endtask

  task automatic setup_tor();
    clear_cfg();
    adr[3] = 54'h400;
    adr[4] = 54'h800;
    cfg[4] = 8'h0F;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    clear_cfg();
    pcfg = cfg;
    padr = adr;
    #12;
    chk("rst_req_ready", ReqReady, 1);
    chk("rst_resp_valid", RespValid, 0);
    chk("rst_fault", Fault, 0);
    chk("rst_match_valid", MatchValid, 0);
    chk("rst_match_idx", MatchIdx, 0);
    @(negedge clk);
    reset_n = 1'b1;

    setup_napot();
    run(64'h8000_0FF8, 2'd3, 3'b001, 2'b00, 0, 0);
    chk("napot_r_fault", gf, 0);
    chk("napot_r_mv", gmv, 1);
    chk("napot_r_idx", gidx, 9);
    chk("napot_r_lat", glat, 3);
    run(64'h8000_0FF8, 2'd3, 3'b010, 2'b00, 0, 0);
    chk("napot_w_fault", gf, 1);
    run(64'h8000_0FFC, 2'd3, 3'b001, 2'b00, 0, 0);
    chk("partial_fault", gf, 1);
    chk("partial_mv", gmv, 0);
    for (int j = 0; j < 16; j++)
      run(64'h8000_0FF0 + j, 2'(j), 3'b001, 2'b01, 0, 0);
    run(64'h7FFF_FFFE, 2'd2, 3'b001, 2'b00, 0, 0);

    setup_tor();
    run(64'h1800, 2'd2, 3'b100, 2'b01, 0, 0);
    chk("tor_idx", gidx, 4);
    chk("tor_fault", gf, 0);
    chk("tor_lat", glat, 2);
    run(64'h0FFC, 2'd2, 3'b100, 2'b01, 0, 0);
    chk("tor_below_fault", gf, 1);
    chk("tor_below_mv", gmv, 0);
    run(64'h1FFE, 2'd2, 3'b100, 2'b01, 0, 0);

    clear_cfg();
    run(64'h1234, 2'd0, 3'b001, 2'b11, 0, 0);
    chk("m_nohit_fault", gf, 0);
    adr[0] = 54'h40;
    cfg[0] = 8'h91;
    run(64'h100, 2'd2, 3'b010, 2'b11, 0, 0);
    chk("m_lock_w_fault", gf, 1);
    chk("m_lock_w_idx", gidx, 0);
    run(64'h100, 2'd2, 3'b001, 2'b11, 0, 0);
    chk("m_lock_r_fault", gf, 0);
    run(64'h00FF_FFFF_FFFF_FFFF, 2'd1, 3'b001, 2'b11, 0, 0);
    chk("ovf_fault", gf, 1);

    setup_tor();
    pcfg = cfg;
    padr = adr;
    pcfg[4] = 8'h09;
    run(64'h1800, 2'd2, 3'b100, 2'b01, 0, 2);
    chk("csr_fault", gf, 1);
    chk("csr_lat", glat, 4);

    setup_napot();
    run(64'h8000_0FF8, 2'd3, 3'b001, 2'b00, 5, 0);
    chk("hold_idx", gidx, 9);

    @(negedge clk);
    ReqValid        = 1'b1;
    PhysicalAddress = 56'h8000_0FF8;
    Size            = 2'd3;
    AccessType      = 3'b001;
    PrivilegeMode   = 2'b00;
    @(posedge clk);
    #1;
    ReqValid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_req_ready", ReqReady, 1);
    chk("midrst_resp_valid", RespValid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_idle", ReqReady, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
